// File: rtl/ysyx_22050019_mem_arb.sv
// ysyx_22050019_mem_arb
// Shares the single memory port between instruction fetch (IF) and the
// load/store unit (LS). One transaction is in flight at a time:
//   IDLE  - pick a winner (LS over IF), handshake, latch payload and owner
//   ISSUE - present the latched request until mem_req_ready
//   WAIT  - on mem_rsp_valid, register data and pulse the owner's rsp_valid
//
// Ports
//   clk, rst_n             clock; synchronous reset, active-HIGH despite the name
//   if_req_*               IF read request (valid/ready/addr)
//   if_rsp_*               IF one-cycle response pulse and read data
//   ls_req_*               LS request (valid/ready/addr/wen/wdata/wmask)
//   ls_rsp_*               LS one-cycle response pulse; data is 0 for writes
//   mem_req_*              latched request towards memory
//   mem_rsp_*              memory response (read data or write ack)
//   busy                   arbiter is not in IDLE
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to stop IF from starving.
// After STARVE_MAX consecutive accepts in which both requested and LS won,
// IF wins the next accept. Without the macro, LS priority is strict.
module ysyx_22050019_mem_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,
    input  logic                  ls_req_valid,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_req_ready,
    output logic                  ls_rsp_valid,
    output logic [DATA_W-1:0]     ls_rsp_data,
    output logic                  mem_req_valid,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // The port keeps its historical name, but a high level means reset.
    logic rst;
    assign rst = rst_n;

    state_t                state_q, state_d;
    logic                  owner_ls_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic                  if_rsp_valid_q, ls_rsp_valid_q;
    logic [DATA_W-1:0]     if_rsp_data_q, ls_rsp_data_q;

    logic grant_ls, grant_if;
    logic force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_if = (starve_q == CNT_W'(STARVE_MAX));

    // Counts LS wins over a waiting IF; saturates at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_ls && if_req_valid && (starve_q != CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict LS priority: IF is never forced ahead.
    assign force_if = (STARVE_MAX < 0);
`endif

    always_comb begin
        state_d  = state_q;
        grant_ls = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            S_IDLE: begin
                // No grant while reset is held: the handshake would be lost.
                if (!rst) begin
                    if (ls_req_valid && !(force_if && if_req_valid)) begin
                        grant_ls = 1'b1;
                    end else if (if_req_valid) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_ls || grant_if) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            owner_ls_q     <= 1'b0;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if (grant_ls) begin
                owner_ls_q <= 1'b1;
                addr_q     <= ls_req_addr;
                wen_q      <= ls_req_wen;
                wdata_q    <= ls_req_wdata;
                wmask_q    <= ls_req_wmask;
            end else if (grant_if) begin
                // IF is read-only; keep write fields clean on the bus.
                owner_ls_q <= 1'b0;
                addr_q     <= if_req_addr;
                wen_q      <= 1'b0;
                wdata_q    <= '0;
                wmask_q    <= '0;
            end
            if ((state_q == S_WAIT) && mem_rsp_valid) begin
                if (owner_ls_q) begin
                    ls_rsp_valid_q <= 1'b1;
                    ls_rsp_data_q  <= wen_q ? '0 : mem_rsp_data;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_data_q  <= mem_rsp_data;
                end
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_data   = ls_rsp_data_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_22050019_mem_arb.sv
// Testbench for ysyx_22050019_mem_arb: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model of the
// arbiter (outstanding flag, latched request, pending response, starvation
// count). Inputs change on the falling edge, outputs are sampled 1 time unit
// later.
module tb_ysyx_22050019_mem_arb;

  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_data;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        busy;

  ysyx_22050019_mem_arb #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: state of the shared port as seen at the start of a cycle.
  bit          m_out;      // a transaction is owned (arbiter not idle)
  bit          m_iss;      // memory has taken the request; waiting for response
  bit          m_own_ls;
  logic [63:0] m_addr, m_wdata;
  bit          m_wen;
  logic [7:0]  m_wmask;
  bit          m_due;      // a response pulse is due this cycle
  bit          m_due_ls;
  logic [63:0] m_due_data;
  int          m_starve;
  bit          e_ls, e_if;
  bit          last_ls_acc, last_if_acc;
  int          lat;

  task automatic sample();
    bit frc;
    #1;
    frc = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    frc = (m_starve == SMAX);
`endif
    e_ls = !rst && !m_out && ls_req_valid && !(frc && if_req_valid);
    e_if = !rst && !m_out && if_req_valid && !e_ls;
    chk("ls_req_ready", ls_req_ready, e_ls);
    chk("if_req_ready", if_req_ready, e_if);
    chk("busy", busy, m_out);
    chk("mem_req_valid", mem_req_valid, m_out && !m_iss);
    if (m_out && !m_iss) begin
      chk("mem_req_addr", mem_req_addr, m_addr);
      chk("mem_req_wen", mem_req_wen, m_wen);
      chk("mem_req_wdata", mem_req_wdata, m_wdata);
      chk("mem_req_wmask", mem_req_wmask, m_wmask);
    end
    chk("if_rsp_valid", if_rsp_valid, m_due && !m_due_ls);
    chk("ls_rsp_valid", ls_rsp_valid, m_due && m_due_ls);
    if (m_due && m_due_ls)  chk("ls_rsp_data", ls_rsp_data, m_due_data);
    if (m_due && !m_due_ls) chk("if_rsp_data", if_rsp_data, m_due_data);
    last_ls_acc = ls_req_valid && ls_req_ready;
    last_if_acc = if_req_valid && if_req_ready;
  endtask

  task automatic adv();
    bit nd;
    if (rst) begin
      m_out = 0; m_iss = 0; m_due = 0; m_starve = 0;
    end else begin
      nd = m_out && m_iss && mem_rsp_valid;
      if (nd) begin
        m_due_ls   = m_own_ls;
        m_due_data = (m_own_ls && m_wen) ? 64'd0 : mem_rsp_data;
        m_out = 0; m_iss = 0;
      end else if (m_out && !m_iss && mem_req_ready) begin
        m_iss = 1;
        lat = $urandom_range(0, 2);
      end else if (e_ls) begin
        m_out = 1; m_own_ls = 1; m_addr = ls_req_addr; m_wen = ls_req_wen;
        m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (if_req_valid && m_starve < SMAX) m_starve++;
`endif
      end else if (e_if) begin
        m_out = 1; m_own_ls = 0; m_addr = if_req_addr; m_wen = 0;
        m_wdata = 0; m_wmask = 0; m_starve = 0;
      end
      m_due = nd;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic rand_drive();
    rst = ($urandom % 250 == 0);
    if (!(ls_req_valid && !last_ls_acc)) begin
      ls_req_valid = ($urandom % 3 == 0);
      ls_req_addr  = {$urandom, $urandom};
      ls_req_wen   = $urandom % 2;
      ls_req_wdata = {$urandom, $urandom};
      ls_req_wmask = 8'($urandom);
    end
    if (!(if_req_valid && !last_if_acc)) begin
      if_req_valid = ($urandom % 2 == 0);
      if_req_addr  = {$urandom, $urandom};
    end
    mem_req_ready = $urandom % 2;
    mem_rsp_data  = {$urandom, $urandom};
    if (m_out && m_iss) begin
      if (lat == 0) mem_rsp_valid = 1;
      else begin
        lat--;
        mem_rsp_valid = 0;
      end
    end else begin
      mem_rsp_valid = ($urandom % 4 == 0);  // ignored outside WAIT
    end
  endtask

  int grants[6];
  int ng;

  initial begin
    rst = 1; if_req_valid = 0; if_req_addr = 0; ls_req_valid = 0; ls_req_addr = 0;
    ls_req_wen = 0; ls_req_wdata = 0; ls_req_wmask = 0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0; lat = 0; m_starve = 0;
    repeat (2) @(negedge clk);

    // Reset state
    rst = 0;
    sample();
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_ls_rsp_valid", ls_rsp_valid, 0);
    chk("rst_if_rsp_data", if_rsp_data, 0);
    chk("rst_ls_rsp_data", ls_rsp_data, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_wdata", mem_req_wdata, 0);
    chk("rst_mem_req_wmask", mem_req_wmask, 0);
    chk("rst_busy", busy, 0);
    adv();

    // IF read
    mem_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0000;
    sample(); chk("ifrd_ready", if_req_ready, 1); adv();
    if_req_valid = 0;
    sample();
    chk("ifrd_addr", mem_req_addr, 64'h8000_0000);
    chk("ifrd_wen", mem_req_wen, 0);
    adv();
    mem_rsp_valid = 1; mem_rsp_data = 64'h13;
    cyc();
    mem_rsp_valid = 0;
    sample();
    chk("ifrd_rsp_valid", if_rsp_valid, 1);
    chk("ifrd_rsp_data", if_rsp_data, 64'h13);
    chk("ifrd_ls_quiet", ls_rsp_valid, 0);
    adv();
    sample(); chk("ifrd_pulse_end", if_rsp_valid, 0); adv();

    // IF and LS together: LS first, IF accepted on the LS response cycle
    ls_req_valid = 1; ls_req_wen = 0; ls_req_addr = 64'h8000_0100;
    if_req_valid = 1; if_req_addr = 64'h8000_0004;
    sample();
    chk("both_ls_ready", ls_req_ready, 1);
    chk("both_if_ready", if_req_ready, 0);
    adv();
    ls_req_valid = 0;
    cyc();
    mem_rsp_valid = 1; mem_rsp_data = 64'haaaa;
    cyc();
    mem_rsp_valid = 0;
    sample();
    chk("both_ls_rsp", ls_rsp_valid, 1);
    chk("both_ls_data", ls_rsp_data, 64'haaaa);
    chk("both_if_accept", if_req_ready, 1);
    adv();
    if_req_valid = 0;
    cyc();
    mem_rsp_valid = 1; mem_rsp_data = 64'hbbbb;
    cyc();
    mem_rsp_valid = 0;
    sample();
    chk("both_if_rsp", if_rsp_valid, 1);
    chk("both_if_data", if_rsp_data, 64'hbbbb);
    adv();

    // LS write
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h8000_1000;
    ls_req_wdata = 64'hdead_beef; ls_req_wmask = 8'h0f;
    cyc();
    ls_req_valid = 0; ls_req_wen = 0; ls_req_wdata = 0; ls_req_wmask = 0; ls_req_addr = 0;
    sample();
    chk("lsw_addr", mem_req_addr, 64'h8000_1000);
    chk("lsw_wen", mem_req_wen, 1);
    chk("lsw_wdata", mem_req_wdata, 64'hdead_beef);
    chk("lsw_wmask", mem_req_wmask, 8'h0f);
    adv();
    mem_rsp_valid = 1; mem_rsp_data = 64'h1234_5678;
    cyc();
    mem_rsp_valid = 0;
    sample();
    chk("lsw_rsp_valid", ls_rsp_valid, 1);
    chk("lsw_rsp_data", ls_rsp_data, 0);
    adv();

    // Memory stall in ISSUE while requesters change their inputs
    mem_req_ready = 0;
    if_req_valid = 1; if_req_addr = 64'h8000_2000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      if_req_valid = $urandom % 2; if_req_addr = {$urandom, $urandom};
      ls_req_valid = $urandom % 2; ls_req_addr = {$urandom, $urandom};
      ls_req_wen = $urandom % 2; ls_req_wdata = {$urandom, $urandom};
      sample();
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, 64'h8000_2000);
      chk("stall_wen", mem_req_wen, 0);
      chk("stall_busy", busy, 1);
      adv();
    end
    if_req_valid = 0; ls_req_valid = 0; ls_req_wen = 0; mem_req_ready = 1;
    cyc();
    mem_rsp_valid = 1; mem_rsp_data = 64'h77;
    cyc();
    mem_rsp_valid = 0;
    sample(); chk("stall_rsp", if_rsp_valid, 1); adv();

    // Grant order with both requesters continuously valid
    rst = 1; cyc(); rst = 0;
    ls_req_valid = 1; ls_req_wen = 0; ls_req_addr = 64'h8000_0200;
    if_req_valid = 1; if_req_addr = 64'h8000_0008;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 64'h99;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      sample();
      if (ls_req_ready) begin grants[ng] = 0; ng++; end
      else if (if_req_ready) begin grants[ng] = 1; ng++; end
      adv();
    end
    chk("grant_count", ng, 6);
    for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk($sformatf("grant%0d", i), grants[i], (i % 3 == 2) ? 1 : 0);
`else
      chk($sformatf("grant%0d", i), grants[i], 0);
`endif
    end
    ls_req_valid = 0; if_req_valid = 0;
    repeat (4) cyc();
    mem_rsp_valid = 0;
    cyc();

    // Reset during WAIT, then a stray response
    if_req_valid = 1; if_req_addr = 64'h8000_3000;
    cyc();
    if_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; mem_rsp_valid = 1; mem_rsp_data = 64'h5a5a;
    sample();
    chk("wrst_busy", busy, 0);
    chk("wrst_mem_valid", mem_req_valid, 0);
    chk("wrst_mem_addr", mem_req_addr, 0);
    chk("wrst_if_rsp_data", if_rsp_data, 0);
    chk("wrst_ls_rsp_data", ls_rsp_data, 0);
    chk("wrst_if_rsp", if_rsp_valid, 0);
    adv();
    mem_rsp_valid = 0;
    sample();
    chk("wrst_no_if_pulse", if_rsp_valid, 0);
    chk("wrst_no_ls_pulse", ls_rsp_valid, 0);
    chk("wrst_idle", busy, 0);
    adv();
    if_req_valid = 1; if_req_addr = 64'h8000_4000;
    sample(); chk("wrst_fresh_ready", if_req_ready, 1); adv();
    if_req_valid = 0;
    sample(); chk("wrst_fresh_addr", mem_req_addr, 64'h8000_4000); adv();
    mem_rsp_valid = 1; mem_rsp_data = 64'h55;
    cyc();
    mem_rsp_valid = 0;
    sample();
    chk("wrst_fresh_rsp", if_rsp_valid, 1);
    chk("wrst_fresh_data", if_rsp_data, 64'h55);
    adv();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      sample();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_mem_arb.md
# ysyx_22050019_mem_arb

Two-requester arbiter that shares the single memory port between instruction fetch (IF) and load/store (LS). It sits between the fetch stage, the LSU and the memory/bus interface. It serialises their accesses: one outstanding transaction at a time, valid/ready request handshake, and a one-cycle response pulse returned to the owning requester.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width
- `STARVE_MAX`, 8, consecutive IF losses before IF is forced to win; used only with `MEM_ARB_STARVE_GUARD_EN`
- `clk`  in  1  clock
- `rst_n`  in  1  one clock; reset is synchronous and active-high (asserted = 1, sampled on `posedge clk`)
- `if_req_valid`  in  1  IF read request
- `if_req_addr`  in  ADDR_W  IF read address
- `if_req_ready`  out  1  IF request accepted this cycle
- `if_rsp_valid`  out  1  IF response pulse
- `if_rsp_data`  out  DATA_W  IF read data
- `ls_req_valid`  in  1  LS request
- `ls_req_addr`  in  ADDR_W  LS address
- `ls_req_wen`  in  1  1 = write, 0 = read
- `ls_req_wdata`  in  DATA_W  write data
- `ls_req_wmask`  in  DATA_W/8  byte write mask
- `ls_req_ready`  out  1  LS request accepted this cycle
- `ls_rsp_valid`  out  1  LS response pulse
- `ls_rsp_data`  out  DATA_W  LS read data; 0 for writes
- `mem_req_valid`  out  1  request to memory
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wmask`  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched payload
- `mem_req_ready`  in  1  memory accepts request
- `mem_rsp_valid`  in  1  memory response (read data or write ack)
- `mem_rsp_data`  in  DATA_W  memory read data
- `busy`  out  1  state != IDLE

## Operation
- FSM has three states.
  - IDLE: picks the winner among valid requesters. Raises that requester's `*_req_ready` combinationally; the other ready stays 0. On handshake, latches the payload and owner, then goes to ISSUE.
  - ISSUE: `mem_req_valid`=1 with the latched payload. On `mem_req_ready` goes to WAIT.
  - WAIT: on `mem_rsp_valid`, registers the data into the owner's `*_rsp_data` and pulses the owner's `*_rsp_valid` for exactly one cycle. Returns to IDLE.
- Priority is LS over IF; the LS instruction is older.
- IF is read-only: the latched wen is 0, wmask is 0 and wdata is 0.
- On an LS write, `ls_rsp_data` is forced to 0.
- `mem_rsp_valid` in IDLE or ISSUE is ignored; it does not change state or outputs.
- Requesters hold valid and payload stable until ready. The arbiter does not depend on payload stability after acceptance.
- A reset asserted in any state forces IDLE, aborts the outstanding transaction and drops its response.
- Reset values: every output 0, state IDLE, starvation counter 0, latched payload 0.

## Timing
- Accept at cycle T; `mem_req_valid` is high from T+1.
- If `mem_req_ready`=1 at T+1, the arbiter is in WAIT from T+2.
- `mem_rsp_valid` at cycle R gives `*_rsp_valid` at R+1. The FSM is in IDLE at R+1, so the next accept can happen at R+1.
- Minimum turnaround is 3 cycles per transaction (T, T+1, T+2 with R = T+2); the next accept is at T+3.
- While `mem_req_ready`=0, `mem_req_valid` and all `mem_req_*` fields hold constant.
- `*_rsp_valid` never lasts more than one cycle and never fires for both requesters in the same cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments at each IDLE accept where both are valid and LS wins.
  - When the counter equals `STARVE_MAX`, IF wins the next accept regardless of LS.
  - The counter clears on any IF grant.
  - The counter width is `$clog2(STARVE_MAX+1)` and it saturates, never wrapping.
- Undefined: strict LS priority, with no counter logic present. IF can starve indefinitely while LS stays valid.

## Test plan
- IF read, addr 0x80000000:
  - Drive `mem_req_ready`=1 and `mem_rsp_valid` with data 0x00000013 at the cycle after ISSUE.
  - Required: `mem_req_addr`=0x80000000 and `mem_req_wen`=0.
  - Required: `if_rsp_valid` pulses one cycle with `if_rsp_data`=0x13, and `ls_rsp_valid` stays 0.
- IF and LS valid in the same cycle:
  - Required: `ls_req_ready`=1 and `if_req_ready`=0.
  - Required: the LS response arrives first, then IF is accepted in the cycle `ls_rsp_valid` pulses.
- LS write, addr 0x80001000, wdata 0xdeadbeef, wmask 0x0f:
  - Required: the `mem_req_*` fields match the stimulus exactly.
  - Required: the ack gives `ls_rsp_valid`=1 with `ls_rsp_data`=0.
- `mem_req_ready` held 0 for 3 cycles in ISSUE, with the requester changing its inputs meanwhile:
  - Required: `mem_req_valid`=1 and the payload stays unchanged.
  - Required: `busy`=1 throughout.
- Macro on, `STARVE_MAX`=2, LS and IF both continuously valid:
  - Required grant order: LS, LS, IF, LS, LS, IF.
  - Macro off: IF is never granted while LS stays valid.
- Reset during WAIT, then `mem_rsp_valid`=1 in the next cycle:
  - Required: all outputs 0 and state IDLE.
  - Required: no `*_rsp_valid` pulse.
  - Required: a fresh IF request is accepted normally.
